// File: rtl/fetch_if.sv
// Handshake/bus bundle between the MIPS fetch stage, instruction memory and decode.
// The misalign_o signal exists only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_if;
    logic        stall_i;
    logic        flush_i;
    logic [1:0]  pc_src_i;
    logic [31:0] branch_target_i;
    logic [31:0] jump_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    modport master (
        input  stall_i, flush_i, pc_src_i, branch_target_i, jump_target_i,
        input  imem_ack_i, imem_rdata_i,
        output imem_req_o, imem_addr_o,
        output if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o
`ifdef FETCH_ALIGN_CHECK_EN
        , output misalign_o
`endif
    );

    modport slave (
        output stall_i, flush_i, pc_src_i, branch_target_i, jump_target_i,
        output imem_ack_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o,
        input  if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o
`ifdef FETCH_ALIGN_CHECK_EN
        , input misalign_o
`endif
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, req/ack imem fetch, skid buffer and IF/ID register.
// Optional misaligned-fetch trap to EXC_VECTOR is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef FETCH_ALIGN_CHECK_EN
    , parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
`endif
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  fif
);
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] buf_q, buf_d;
    logic        valid_q, valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_instr_q, id_instr_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_q, misalign_d;
    logic        load_mis_s;
`endif

    logic        ack_s;
    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] pc_plus4_s;
    logic        load_s;
    logic [31:0] load_instr_s;

    function automatic logic is_aligned(input logic [31:0] a);
        return (a[1:0] == 2'b00);
    endfunction

    // An ack only counts against a request that is actually on the bus.
    assign ack_s      = req_q & fif.imem_ack_i;
    assign redirect_s = (fif.pc_src_i == 2'b01) || (fif.pc_src_i == 2'b10);
    assign pc_plus4_s = pc_q + 32'd4;

    // Target select; without the trap, targets are word-aligned by construction.
    always_comb begin
        target_s = (fif.pc_src_i == 2'b01) ? fif.branch_target_i : fif.jump_target_i;
`ifndef FETCH_ALIGN_CHECK_EN
        target_s = target_s & 32'hFFFF_FFFC;
`endif
    end

    // Next-state, next-PC and IF/ID update logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        req_d        = req_q;
        buf_d        = buf_q;
        valid_d      = valid_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
        id_instr_d   = id_instr_q;
        load_s       = 1'b0;
        load_instr_s = buf_q;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d   = misalign_q;
        load_mis_s   = 1'b0;
`endif
        if (redirect_s) begin
            pc_d    = target_s;
            valid_d = 1'b0;
            // An unacked request must still be drained before the new address goes out.
            if ((state_q == S_FETCH || state_q == S_DISCARD) && req_q && !fif.imem_ack_i) begin
                state_d = S_DISCARD;
            end else begin
                state_d = S_FETCH;
                addr_d  = target_s;
                req_d   = is_aligned(target_s);
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (ack_s) begin
                        if (fif.stall_i) begin
                            buf_d   = fif.imem_rdata_i;
                            state_d = S_HOLD;
                            req_d   = 1'b0;
                        end else begin
                            load_s       = 1'b1;
                            load_instr_s = fif.imem_rdata_i;
                            pc_d         = pc_plus4_s;
                            addr_d       = pc_plus4_s;
                            req_d        = 1'b1;
                        end
`ifdef FETCH_ALIGN_CHECK_EN
                    end else if (!req_q && !is_aligned(pc_q)) begin
                        if (!fif.stall_i) begin
                            load_s       = 1'b1;
                            load_instr_s = 32'h0000_0000;
                            load_mis_s   = 1'b1;
                            pc_d         = EXC_VECTOR;
                            addr_d       = EXC_VECTOR;
                            req_d        = 1'b1;
                        end else begin
                            req_d = 1'b0;
                        end
`endif
                    end else if (!req_q) begin
                        addr_d = pc_q;
                        req_d  = 1'b1;
                    end else begin
                        req_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!fif.stall_i) begin
                        load_s       = 1'b1;
                        load_instr_s = buf_q;
                        pc_d         = pc_plus4_s;
                        addr_d       = pc_plus4_s;
                        req_d        = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        req_d = 1'b0;
                    end
                end
                S_DISCARD: begin
                    if (ack_s) begin
                        state_d = S_FETCH;
                        addr_d  = pc_q;
                        req_d   = is_aligned(pc_q);
                    end else begin
                        req_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                    req_d   = 1'b0;
                end
            endcase

            // Flush kills only what IF/ID holds now; a fresh load still lands as valid.
            if (load_s) begin
                valid_d    = 1'b1;
                id_pc_d    = pc_q;
                id_pc4_d   = pc_plus4_s;
                id_instr_d = load_instr_s;
`ifdef FETCH_ALIGN_CHECK_EN
                misalign_d = load_mis_s;
`endif
            end else if (fif.flush_i || !fif.stall_i) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end
    end

    // State, PC, request and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_VECTOR;
            addr_q     <= RESET_VECTOR;
            req_q      <= 1'b0;
            buf_q      <= 32'h0000_0000;
            valid_q    <= 1'b0;
            id_pc_q    <= 32'h0000_0000;
            id_pc4_q   <= 32'h0000_0000;
            id_instr_q <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            buf_q      <= buf_d;
            valid_q    <= valid_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_instr_q <= id_instr_d;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign fif.imem_req_o    = req_q;
    assign fif.imem_addr_o   = addr_q;
    assign fif.if_id_valid_o = valid_q;
    assign fif.if_id_pc_o    = id_pc_q;
    assign fif.if_id_pc4_o   = id_pc4_q;
    assign fif.if_id_instr_o = id_instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fif.misalign_o    = misalign_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr ^ 32'hA500_0000 as the instruction word.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;

    fetch_if fif ();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present memory data for the address on the bus, clock once, sample 1ns later.
    task automatic cyc();
        fif.imem_rdata_i = fif.imem_addr_o ^ 32'hA500_0000;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n               = 1'b0;
        fif.stall_i         = 1'b0;
        fif.flush_i         = 1'b0;
        fif.pc_src_i        = 2'b00;
        fif.branch_target_i = 32'h0000_0000;
        fif.jump_target_i   = 32'h0000_0000;
        fif.imem_ack_i      = 1'b0;
        fif.imem_rdata_i    = 32'h0000_0000;

        cyc();
        cyc();
        rst_n = 1'b1;
        chk("rst_req",   {31'd0, fif.imem_req_o},    32'd0);
        chk("rst_valid", {31'd0, fif.if_id_valid_o}, 32'd0);
        chk("rst_pc",    fif.if_id_pc_o,    32'h0000_0000);
        chk("rst_pc4",   fif.if_id_pc4_o,   32'h0000_0000);
        chk("rst_instr", fif.if_id_instr_o, 32'h0000_0000);

        cyc();
        chk("first_req",  {31'd0, fif.imem_req_o}, 32'd1);
        chk("first_addr", fif.imem_addr_o, 32'h0000_0000);

        // T1: reset asserted while a request is outstanding
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t1_req_in_rst",   {31'd0, fif.imem_req_o},    32'd0);
        chk("t1_valid_in_rst", {31'd0, fif.if_id_valid_o}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t1_req_after",  {31'd0, fif.imem_req_o}, 32'd1);
        chk("t1_addr_after", fif.imem_addr_o, 32'h0000_0000);

        // T2: zero-wait stream
        fif.imem_ack_i = 1'b1;
        cyc();
        chk("t2_valid0", {31'd0, fif.if_id_valid_o}, 32'd1);
        chk("t2_pc0",    fif.if_id_pc_o,    32'h0000_0000);
        chk("t2_pc4_0",  fif.if_id_pc4_o,   32'h0000_0004);
        chk("t2_instr0", fif.if_id_instr_o, 32'hA500_0000);
        chk("t2_addr4",  fif.imem_addr_o,   32'h0000_0004);
        cyc();
        chk("t2_pc1",    fif.if_id_pc_o,    32'h0000_0004);
        chk("t2_pc4_1",  fif.if_id_pc4_o,   32'h0000_0008);
        chk("t2_instr1", fif.if_id_instr_o, 32'hA500_0004);

        // T3: stall on the ack of address 8
        fif.stall_i = 1'b1;
        cyc();
        chk("t3_hold_pc",    fif.if_id_pc_o, 32'h0000_0004);
        chk("t3_hold_valid", {31'd0, fif.if_id_valid_o}, 32'd1);
        chk("t3_hold_req",   {31'd0, fif.imem_req_o},    32'd0);
        cyc();
        cyc();
        chk("t3_hold_pc3",    fif.if_id_pc_o,    32'h0000_0004);
        chk("t3_hold_instr3", fif.if_id_instr_o, 32'hA500_0004);
        chk("t3_hold_req3",   {31'd0, fif.imem_req_o}, 32'd0);
        fif.stall_i = 1'b0;
        cyc();
        chk("t3_rel_pc",    fif.if_id_pc_o,    32'h0000_0008);
        chk("t3_rel_instr", fif.if_id_instr_o, 32'hA500_0008);
        chk("t3_rel_valid", {31'd0, fif.if_id_valid_o}, 32'd1);
        chk("t3_rel_addr",  fif.imem_addr_o, 32'h0000_000C);
        chk("t3_rel_req",   {31'd0, fif.imem_req_o}, 32'd1);
        cyc();
        chk("t2_pc3",   fif.if_id_pc_o,  32'h0000_000C);
        chk("t2_pc4_3", fif.if_id_pc4_o, 32'h0000_0010);

        // T4: jump while address 0x10 is still unacked
        fif.imem_ack_i    = 1'b0;
        fif.pc_src_i      = 2'b10;
        fif.jump_target_i = 32'h0000_0100;
        cyc();
        chk("t4_valid", {31'd0, fif.if_id_valid_o}, 32'd0);
        chk("t4_addr",  fif.imem_addr_o, 32'h0000_0010);
        chk("t4_req",   {31'd0, fif.imem_req_o}, 32'd1);
        fif.pc_src_i = 2'b00;
        cyc();
        chk("t4_wait_addr",  fif.imem_addr_o, 32'h0000_0010);
        chk("t4_wait_valid", {31'd0, fif.if_id_valid_o}, 32'd0);
        fif.imem_ack_i = 1'b1;
        cyc();
        chk("t4_drop_valid", {31'd0, fif.if_id_valid_o}, 32'd0);
        chk("t4_new_addr",   fif.imem_addr_o, 32'h0000_0100);
        cyc();
        chk("t4_pc",    fif.if_id_pc_o,    32'h0000_0100);
        chk("t4_instr", fif.if_id_instr_o, 32'hA500_0100);
        chk("t4_live",  {31'd0, fif.if_id_valid_o}, 32'd1);

        // T5: branch wins over a concurrent stall
        fif.pc_src_i        = 2'b01;
        fif.branch_target_i = 32'h0000_0040;
        fif.stall_i         = 1'b1;
        cyc();
        chk("t5_valid", {31'd0, fif.if_id_valid_o}, 32'd0);
        chk("t5_addr",  fif.imem_addr_o, 32'h0000_0040);
        chk("t5_req",   {31'd0, fif.imem_req_o}, 32'd1);
        fif.pc_src_i = 2'b00;
        fif.stall_i  = 1'b0;
        cyc();
        chk("t5_pc",  fif.if_id_pc_o,  32'h0000_0040);
        chk("t5_pc4", fif.if_id_pc4_o, 32'h0000_0044);

        // Flush alone kills IF/ID; flush with ack still loads the new word
        fif.flush_i    = 1'b1;
        fif.imem_ack_i = 1'b0;
        cyc();
        chk("fl_valid", {31'd0, fif.if_id_valid_o}, 32'd0);
        chk("fl_pc",    fif.if_id_pc_o,  32'h0000_0040);
        chk("fl_addr",  fif.imem_addr_o, 32'h0000_0044);
        fif.imem_ack_i = 1'b1;
        cyc();
        chk("fl_ack_valid", {31'd0, fif.if_id_valid_o}, 32'd1);
        chk("fl_ack_pc",    fif.if_id_pc_o,    32'h0000_0044);
        chk("fl_ack_instr", fif.if_id_instr_o, 32'hA500_0044);
        fif.flush_i = 1'b0;

        // pc+4 wraps at the top of the address space
        fif.pc_src_i      = 2'b10;
        fif.jump_target_i = 32'hFFFF_FFFC;
        cyc();
        chk("wrap_addr", fif.imem_addr_o, 32'hFFFF_FFFC);
        fif.pc_src_i = 2'b00;
        cyc();
        chk("wrap_pc",    fif.if_id_pc_o,    32'hFFFF_FFFC);
        chk("wrap_pc4",   fif.if_id_pc4_o,   32'h0000_0000);
        chk("wrap_instr", fif.if_id_instr_o, 32'h5AFF_FFFC);
        chk("wrap_next",  fif.imem_addr_o,   32'h0000_0000);

        // Misaligned branch target 0x42
        fif.pc_src_i        = 2'b01;
        fif.branch_target_i = 32'h0000_0042;
        cyc();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6_no_req", {31'd0, fif.imem_req_o}, 32'd0);
        fif.pc_src_i = 2'b00;
        cyc();
        chk("t6_mis",   {31'd0, fif.misalign_o},    32'd1);
        chk("t6_valid", {31'd0, fif.if_id_valid_o}, 32'd1);
        chk("t6_pc",    fif.if_id_pc_o,    32'h0000_0042);
        chk("t6_pc4",   fif.if_id_pc4_o,   32'h0000_0046);
        chk("t6_instr", fif.if_id_instr_o, 32'h0000_0000);
        chk("t6_addr",  fif.imem_addr_o,   32'h0000_0080);
        chk("t6_req",   {31'd0, fif.imem_req_o}, 32'd1);
        cyc();
        chk("t6_clear", {31'd0, fif.misalign_o}, 32'd0);
        chk("t6_exc_pc", fif.if_id_pc_o, 32'h0000_0080);
`else
        chk("al_addr", fif.imem_addr_o, 32'h0000_0040);
        chk("al_req",  {31'd0, fif.imem_req_o}, 32'd1);
        fif.pc_src_i = 2'b00;
        cyc();
        chk("al_pc",    fif.if_id_pc_o,    32'h0000_0040);
        chk("al_instr", fif.if_id_instr_o, 32'hA500_0040);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
